// File: rtl/mcp3008_spi_responder.sv
// MCP3004/3008-style SPI target: oversamples sclk/cs_n/din, decodes the start/SGL/D2..D0
// command and shifts back NULL_BITS zeros followed by a 10-bit sample from ch_data.
module mcp3008_spi_responder #(
  parameter int CHANNELS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DIN_SAMPLE_FALL = 0,
  parameter int NULL_BITS       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    din,
  output logic                    dout,
  output logic                    dout_oe,
  input  logic [10*CHANNELS-1:0]  ch_data,
  output logic                    cmd_sgl,
  output logic [2:0]              cmd_ch,
  output logic [9:0]              sample_value,
  output logic                    frame_done,
  output logic                    frame_abort
);

  localparam int         CH_W      = (CHANNELS == 4) ? 2 : 3;
  localparam logic [3:0] NULL_LAST = 4'(NULL_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CMD, S_SAMPLE, S_SHIFT, S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cmd_sr_q, cmd_sr_d;
  logic       dout_q, dout_d;
  logic       dout_oe_q, dout_oe_d;
  logic       cmd_sgl_q, cmd_sgl_d;
  logic [2:0] cmd_ch_q, cmd_ch_d;
  logic [9:0] sample_q, sample_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_abort_q, frame_abort_d;

  logic       sclk_s, cs_s, din_s;
  logic       sclk_rise, sclk_fall, cap;
  logic [9:0] ch_arr [CHANNELS];
  logic [9:0] ch_sel;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    cap         = (DIN_SAMPLE_FALL != 0) ? sclk_fall : sclk_rise;
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) ch_arr[k] = ch_data[10*k +: 10];
    ch_sel = ch_arr[cmd_ch_q[CH_W-1:0]];
  end

  // State register, synchronizers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      din_sync_q    <= '0;
      sclk_prev_q   <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_sr_q      <= '0;
      dout_q        <= 1'b0;
      dout_oe_q     <= 1'b0;
      cmd_sgl_q     <= 1'b0;
      cmd_ch_q      <= '0;
      sample_q      <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      din_sync_q    <= din_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_sr_q      <= cmd_sr_d;
      dout_q        <= dout_d;
      dout_oe_q     <= dout_oe_d;
      cmd_sgl_q     <= cmd_sgl_d;
      cmd_ch_q      <= cmd_ch_d;
      sample_q      <= sample_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Next-state: cs_n high takes priority over any sclk edge seen on the same clk
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_sr_d = cmd_sr_q;
    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_START;
        S_WAIT_START: begin
          if (cap && din_s) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (cap) begin
            cmd_sr_d = {cmd_sr_q[1:0], din_s};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd3) begin
              state_d = S_SAMPLE;
              cnt_d   = '0;
            end
          end
        end
        S_SAMPLE: begin
          if (sclk_fall) begin
            if (cnt_q == NULL_LAST) begin
              state_d = S_SHIFT;
              cnt_d   = 4'd9;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_SHIFT: begin
          if (sclk_fall) begin
            if (cnt_q == 4'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: dout only changes on detected sclk falls so the master sees it stable at its rise
  always_comb begin
    dout_d        = dout_q;
    dout_oe_d     = dout_oe_q;
    cmd_sgl_d     = cmd_sgl_q;
    cmd_ch_d      = cmd_ch_q;
    sample_d      = sample_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    if (cs_s) begin
      dout_d        = 1'b0;
      dout_oe_d     = 1'b0;
      frame_abort_d = (state_q == S_CMD) || (state_q == S_SAMPLE) || (state_q == S_SHIFT);
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_d    = 1'b0;
          dout_oe_d = 1'b1;
        end
        S_CMD: begin
          if (cap && (cnt_q == 4'd3)) begin
            cmd_sgl_d = cmd_sr_q[2];
            cmd_ch_d  = {((CHANNELS == 4) ? 1'b0 : cmd_sr_q[1]), cmd_sr_q[0], din_s};
          end
        end
        S_SAMPLE: begin
          if (sclk_fall) begin
            dout_d = 1'b0;
            if (cnt_q == 4'd0) sample_d = ch_sel;
          end
        end
        S_SHIFT: begin
          if (sclk_fall) begin
            dout_d       = sample_q[cnt_q];
            frame_done_d = (cnt_q == 4'd0);
          end
        end
        S_DONE: begin
          if (sclk_fall) dout_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dout         = dout_q;
  assign dout_oe      = dout_oe_q;
  assign cmd_sgl      = cmd_sgl_q;
  assign cmd_ch       = cmd_ch_q;
  assign sample_value = sample_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Bench for mcp3008_spi_responder: one instance captures din on sclk rise, one on sclk fall;
// a bus-master task drives frames and results are compared with a per-channel value model.
module tb_mcp3008_spi_responder;

  localparam int H = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, din;
  logic [79:0] ch_data;

  logic       dout_r, dout_oe_r, cmd_sgl_r, frame_done_r, frame_abort_r;
  logic [2:0] cmd_ch_r;
  logic [9:0] sample_value_r;
  logic       dout_f, dout_oe_f, cmd_sgl_f, frame_done_f, frame_abort_f;
  logic [2:0] cmd_ch_f;
  logic [9:0] sample_value_f;

  mcp3008_spi_responder #(.DIN_SAMPLE_FALL(0)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout_r), .dout_oe(dout_oe_r), .ch_data(ch_data),
    .cmd_sgl(cmd_sgl_r), .cmd_ch(cmd_ch_r), .sample_value(sample_value_r),
    .frame_done(frame_done_r), .frame_abort(frame_abort_r));

  mcp3008_spi_responder #(.DIN_SAMPLE_FALL(1)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout_f), .dout_oe(dout_oe_f), .ch_data(ch_data),
    .cmd_sgl(cmd_sgl_f), .cmd_ch(cmd_ch_f), .sample_value(sample_value_f),
    .frame_done(frame_done_f), .frame_abort(frame_abort_f));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ndone_r = 0, nabort_r = 0, ndone_f = 0, nabort_f = 0;
  int snap_done, snap_abort;

  always @(posedge clk) begin
    if (frame_done_r)  ndone_r  <= ndone_r + 1;
    if (frame_abort_r) nabort_r <= nabort_r + 1;
    if (frame_done_f)  ndone_f  <= ndone_f + 1;
    if (frame_abort_f) nabort_f <= nabort_f + 1;
  end

  logic [9:0] mch [8];
  logic       samp [40];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ch();
    for (int k = 0; k < 8; k++) ch_data[10*k +: 10] = mch[k];
  endtask

  task automatic rand_ch();
    for (int k = 0; k < 8; k++) mch[k] = 10'($urandom);
  endtask

  // act: 0 full frame, 1 raise cs_n after fall of stop_cyc, 2 pulse rst_n after fall of stop_cyc
  task automatic run_frame(input bit fm, input int lead0, input logic [3:0] cmd,
                           input int act, input int stop_cyc,
                           input int chg_cyc, input logic [79:0] chg_val);
    int  ncyc;
    logic b;
    ncyc = lead0 + 16 + int'(fm);
    snap_done  = fm ? ndone_f  : ndone_r;
    snap_abort = fm ? nabort_f : nabort_r;
    for (int i = 0; i < 40; i++) samp[i] = 1'b0;
    din  = 1'b0;
    cs_n = 1'b0;
    repeat (H) @(posedge clk);
    #1 check("oe_after_cs_fall", fm ? dout_oe_f : dout_oe_r, 1);
    for (int c = 0; c < ncyc; c++) begin
      if (c < lead0)           b = 1'b0;
      else if (c == lead0)     b = 1'b1;
      else if (c <= lead0 + 4) b = cmd[3 - (c - lead0 - 1)];
      else                     b = 1'b0;
      if (!fm) din = b;
      repeat (H) @(posedge clk);
      #1 samp[c] = fm ? dout_f : dout_r;
      if (c == chg_cyc) ch_data = chg_val;
      sclk = 1'b1;
      if (fm) din = b;
      repeat (H) @(posedge clk);
      #1 sclk = 1'b0;
      if (act != 0 && c == stop_cyc) break;
    end
    if (act == 1) begin
      repeat (H) @(posedge clk);
      #1 cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("oe_low_after_abort", fm ? dout_oe_f : dout_oe_r, 0);
    end else if (act == 2) begin
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("mid_reset_outputs",
               {dout_r, dout_oe_r, cmd_sgl_r, cmd_ch_r, sample_value_r, frame_done_r, frame_abort_r}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (H) @(posedge clk);
      #1 cs_n = 1'b1;
    end else begin
      repeat (H) @(posedge clk);
      #1 cs_n = 1'b1;
    end
    din = 1'b0;
    repeat (2 * H) @(posedge clk);
    #1;
  endtask

  // Reference: NULL_BITS=1 zero, then the selected channel value MSB first
  task automatic check_frame(input string tag, input bit fm, input int lead0,
                             input logic [3:0] cmd, input logic [9:0] expv);
    logic [10:0] obs;
    int first;
    first = lead0 + 5 + int'(fm);
    for (int k = 0; k <= 10; k++) obs[10 - k] = samp[first + k];
    check({tag, "_bits"}, obs, {1'b0, expv});
    check({tag, "_sgl"}, fm ? cmd_sgl_f : cmd_sgl_r, cmd[3]);
    check({tag, "_ch"}, fm ? cmd_ch_f : cmd_ch_r, cmd[2:0]);
    check({tag, "_sample"}, fm ? sample_value_f : sample_value_r, expv);
    check({tag, "_done_pulses"}, (fm ? ndone_f : ndone_r) - snap_done, 1);
    check({tag, "_abort_pulses"}, (fm ? nabort_f : nabort_r) - snap_abort, 0);
    check({tag, "_oe_idle"}, fm ? dout_oe_f : dout_oe_r, 0);
  endtask

  initial begin
    logic [79:0] nv;
    logic [3:0]  rc;
    logic [3:0]  obs4;
    int          l0;
    bit          rfm;

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; din = 1'b0;
    rand_ch(); load_ch();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout_r, 0);
    check("rst_oe", dout_oe_r, 0);
    check("rst_cmd", {cmd_sgl_r, cmd_ch_r}, 0);
    check("rst_sample", sample_value_r, 0);
    check("rst_pulses", {frame_done_r, frame_abort_r, frame_done_f, frame_abort_f}, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Nominal frame, channel 5
    rand_ch(); mch[5] = 10'h2A7; load_ch();
    run_frame(1'b0, 0, 4'b1101, 0, 0, -1, ch_data);
    check_frame("nominal", 1'b0, 0, 4'b1101, mch[5]);

    // Three leading zeros, differential channel 3
    rand_ch(); mch[3] = 10'h3FF; load_ch();
    run_frame(1'b0, 3, 4'b0011, 0, 0, -1, ch_data);
    check_frame("lead0", 1'b0, 3, 4'b0011, mch[3]);

    // Abort after B6 has been driven
    rand_ch(); load_ch();
    run_frame(1'b0, 0, 4'b1110, 1, 8, -1, ch_data);
    for (int k = 0; k < 4; k++) obs4[3 - k] = samp[5 + k];
    check("abort_bits", obs4, {1'b0, mch[6][9:7]});
    check("abort_pulses", nabort_r - snap_abort, 1);
    check("abort_no_done", ndone_r - snap_done, 0);
    check("abort_sample_kept", sample_value_r, mch[6]);
    rand_ch(); load_ch();
    run_frame(1'b0, 1, 4'b1001, 0, 0, -1, ch_data);
    check_frame("post_abort", 1'b0, 1, 4'b1001, mch[1]);

    // ch2 changes after the null bit
    rand_ch(); mch[2] = 10'h100; load_ch();
    nv = ch_data; nv[20 +: 10] = 10'h0FF;
    run_frame(1'b0, 0, 4'b1010, 0, 0, 5, nv);
    check_frame("data_change", 1'b0, 0, 4'b1010, 10'h100);
    mch[2] = 10'h0FF;

    // Fall-capture instance, master changes din on rising edge
    rand_ch(); mch[5] = 10'h2A7; load_ch();
    run_frame(1'b1, 0, 4'b1101, 0, 0, -1, ch_data);
    check_frame("fall_mode", 1'b1, 0, 4'b1101, mch[5]);

    // Reset pulse while shifting
    rand_ch(); load_ch();
    run_frame(1'b0, 0, 4'b1111, 2, 10, -1, ch_data);
    check("rst_mid_no_done", ndone_r - snap_done, 0);
    check("rst_mid_no_abort", nabort_r - snap_abort, 0);
    check("rst_mid_oe", dout_oe_r, 0);
    rand_ch(); load_ch();
    run_frame(1'b0, 0, 4'b1100, 0, 0, -1, ch_data);
    check_frame("post_reset", 1'b0, 0, 4'b1100, mch[4]);

    // Randomized frames on either instance
    for (int n = 0; n < 6; n++) begin
      rand_ch(); load_ch();
      rc  = 4'($urandom);
      l0  = int'($urandom_range(0, 3));
      rfm = 1'($urandom_range(0, 1));
      run_frame(rfm, l0, rc, 0, 0, -1, ch_data);
      check_frame("random", rfm, l0, rc, mch[rc[2:0]]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcp3008_spi_responder.md
Name: mcp3008_spi_responder

Overview:
- Synthesizable SPI responder that emulates an MCP3004/3008-style 10-bit SAR ADC. It is the target-side counterpart of the ADC-reading SPI master.
- Oversamples the master's AD_CLK, CS and DIN with the system clock, decodes the start/SGL/D2..D0 command, and shifts back a null bit plus a 10-bit sample taken from a per-channel data bus.
- Used as an on-FPGA loopback target and bench model for the Pmod ADC master, so master logic can be checked without the physical ADC.

Parameters:
- CHANNELS, 8, number of emulated channels (4 or 8); command D2 is ignored when 4.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/din (minimum 2).
- DIN_SAMPLE_FALL, 0, 0 = capture din on detected sclk rising edge (datasheet timing); 1 = capture on falling edge (for masters that change DIN on the rising edge).
- NULL_BITS, 1, number of zero bits driven before B9.

Ports:
- clk  input  1  system clock; must be at least 4x sclk frequency
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock from master (AD_CLK)
- cs_n  input  1  chip select, active low
- din  input  1  command data from master
- dout  output  1  serial data to master
- dout_oe  output  1  high while dout is actively driven (top-level tristate enable)
- ch_data  input  10*CHANNELS  channel k value at [10k+9:10k]
- cmd_sgl  output  1  SGL/DIFF bit of last valid command
- cmd_ch  output  3  D2..D0 of last valid command
- sample_value  output  10  value latched for the current/last frame
- frame_done  output  1  one-clk pulse when B0 has been driven
- frame_abort  output  1  one-clk pulse when cs_n rises mid-frame

Behaviour:
- Reset values: dout=0, dout_oe=0, cmd_sgl=0, cmd_ch=0, sample_value=0, frame_done=0, frame_abort=0. All synchronizer flops reset to the idle levels sclk=0, cs_n=1, din=0. State is IDLE.
- Synchronization and edge detection:
  - sclk, cs_n and din pass through SYNC_STAGES flops.
  - Edge detect compares the last two synchronized sclk samples. rise/fall are each one-clk strobes.
  - The din capture edge is set by DIN_SAMPLE_FALL.
- States:
  - IDLE: cs_n high. Synchronized cs_n falling moves to WAIT_START; dout_oe goes to 1 and dout to 0 on that same clk.
  - WAIT_START: leading din=0 bits on capture edges are ignored. The first captured 1 is the start bit -> CMD with bit count 0.
  - CMD: captures 4 bits in order SGL, D2, D1, D0. After the 4th capture -> SAMPLE. cmd_sgl/cmd_ch update only at this point; if CHANNELS=4, cmd_ch[2] is forced to 0.
  - SAMPLE: on the next sclk fall, latch ch_data[cmd_ch] into sample_value and drive dout=0 (null bit). Stay for NULL_BITS falls, then -> SHIFT.
  - SHIFT: each sclk fall drives the next bit, B9 first down to B0. On the fall that drives B0, pulse frame_done (registered, 1 clk) -> DONE.
  - DONE: dout held 0, further sclk edges ignored, wait for cs_n high.
- cs_n rise handling:
  - From any state, synchronized cs_n high returns to IDLE on the next clk with dout_oe=0 and dout=0.
  - If cs_n rises in CMD, SAMPLE or SHIFT, frame_abort pulses for 1 clk. In that case sample_value keeps the latched value and cmd_* are unchanged if the abort came before the command completed.
  - No abort pulse from IDLE, WAIT_START or DONE.
- Simultaneous events: if cs_n rise and an sclk edge are detected on the same clk, cs_n wins and the edge is discarded.
- ch_data is sampled only at the SAMPLE latch instant; later changes do not affect the frame in flight.
- Latency: dout updates 1 clk after the synchronized fall strobe, i.e. SYNC_STAGES+1 clks after the physical sclk fall.
- Reset asserted mid-frame: immediate return to reset values, with no frame_done or frame_abort pulse.

Test Plan:
- Nominal frame: ch_data ch5=10'h2A7, command 1,1,1,0,1 -> cmd_sgl=1, cmd_ch=5, dout bits 0,1,0,1,0,1,0,0,1,1,1, frame_done single pulse, sample_value=10'h2A7.
- Leading zeros: 3 zero bits before start, command SGL=0, ch=3, ch3=10'h3FF -> cmd_sgl=0, cmd_ch=3, B9..B0 all 1.
- Abort: cs_n raised after B6 is driven -> frame_abort single pulse, no frame_done, dout_oe=0 within SYNC_STAGES+1 clks, next frame decodes normally.
- Data change: ch2 changes from 10'h100 to 10'h0FF after the null bit -> shifted value remains 10'h100.
- DIN_SAMPLE_FALL=1 with the master driving DIN on the rising edge, 5 sclk cycles per command -> same decode as the nominal frame.
- Reset mid-SHIFT: rst_n low for 1 clk -> all outputs 0, IDLE, no pulses; next frame correct.
